// File: rtl/regfile_pkg.sv
// Shared widths and types for the datapath register bank.
package regfile_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage : regfile_pkg

// File: rtl/reg_file.sv
// 16x16 register bank: two combinational read ports, one unconditional write port.
module reg_file
    import regfile_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] Re1,
    input  logic [ADDR_W-1:0] Re2,
    input  logic [ADDR_W-1:0] W,
    input  logic [DATA_W-1:0] Da,
    output logic [DATA_W-1:0] D1,
    output logic [DATA_W-1:0] D2
);

    // Storage keeps the name N so entries can be probed as N[i].
    reg_data_t N   [NUM_REGS];
    reg_data_t n_d [NUM_REGS];

    // Next contents: reset clears everything and drops the write; otherwise only N[W] takes Da.
    always_comb begin
        n_d = N;
        if (Rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                n_d[i] = '0;
            end
        end else begin
            n_d[W] = Da;
        end
    end

    // State update on the rising edge; reset is synchronous, folded into n_d.
    always_ff @(posedge Clk) begin
        N <= n_d;
    end

    // Read ports are plain muxes with no bypass: a same-address write shows up after the edge.
    always_comb begin
        D1 = N[Re1];
        D2 = N[Re2];
    end

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed bench for reg_file with hand-computed expectations.
`timescale 1ns/1ps
module tb_reg_file;

    logic        Clk;
    logic        Rst;
    logic [3:0]  Re1;
    logic [3:0]  Re2;
    logic [3:0]  W;
    logic [15:0] Da;
    logic [15:0] D1;
    logic [15:0] D2;

    int n_cmp;
    int n_mis;

    reg_file dut (
        .Clk (Clk),
        .Rst (Rst),
        .Re1 (Re1),
        .Re2 (Re2),
        .W   (W),
        .Da  (Da),
        .D1  (D1),
        .D2  (D2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle 1 time unit so inputs/outputs are away from the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    logic [15:0] stream;

    initial begin
        n_cmp = 0;
        n_mis = 0;
        Rst = 1'b0;
        Re1 = 4'd0;
        Re2 = 4'd0;
        W   = 4'd2;
        Da  = 16'h00AB;

        // Preload N[2] through the write port.
        tick();
        check_eq("preload_n2", dut.N[2], 16'h00AB);

        // Reset edge with a competing write: the write must be dropped.
        Rst = 1'b1;
        W   = 4'd2;
        Da  = 16'hFFFF;
        tick();
        Rst = 1'b0;
        W   = 4'd15;
        Da  = 16'h0000;
        check_eq("rst_n2_cleared", dut.N[2], 16'h0000);
        for (int a = 0; a < 16; a++) begin
            check_eq($sformatf("rst_n%0d", a), dut.N[a], 16'h0000);
        end
        Re1 = 4'd0;  Re2 = 4'd2;  #1;
        check_eq("rst_d1_a0", D1, 16'h0000);
        check_eq("rst_d2_a2", D2, 16'h0000);
        Re1 = 4'd15; Re2 = 4'd15; #1;
        check_eq("rst_d1_a15", D1, 16'h0000);
        check_eq("rst_d2_a15", D2, 16'h0000);
        Re1 = 4'd2;  Re2 = 4'd0;  #1;
        check_eq("rst_d1_a2", D1, 16'h0000);
        check_eq("rst_d2_a0", D2, 16'h0000);

        // Basic write then read.
        W  = 4'd2;
        Da = 16'h000F;
        tick();
        W  = 4'd15;
        Da = 16'h0000;
        Re1 = 4'd2;
        Re2 = 4'd1;
        #1;
        check_eq("basic_d1_a2", D1, 16'h000F);
        check_eq("basic_d2_a1", D2, 16'h0000);

        // Back-to-back writes on successive edges.
        W  = 4'd3;
        Da = 16'h001E;
        tick();
        W  = 4'd4;
        Da = 16'h002D;
        tick();
        W  = 4'd15;
        Da = 16'h0000;
        Re1 = 4'd3;
        Re2 = 4'd4;
        #1;
        check_eq("b2b_d1_a3", D1, 16'h001E);
        check_eq("b2b_d2_a4", D2, 16'h002D);
        check_eq("b2b_n2_hold", dut.N[2], 16'h000F);

        // Same-address read/write: old value before the edge, new value right after.
        Re1 = 4'd5;
        W   = 4'd5;
        Da  = 16'h1234;
        #1;
        check_eq("same_before", D1, 16'h0000);
        tick();
        check_eq("same_after", D1, 16'h1234);
        W  = 4'd15;
        Da = 16'h0000;

        // Load N[i] = i*0x0F, then sweep reads with no clock edges.
        for (int i = 0; i < 16; i++) begin
            W  = 4'(i);
            Da = 16'(i * 15);
            tick();
        end
        // Park on entry 15 rewriting its own value so later edges change nothing.
        W  = 4'd15;
        Da = 16'h00E1;
        for (int i = 0; i < 16; i++) begin
            Re1 = 4'(i);
            Re2 = 4'((i + 1) % 16);
            #1;
            check_eq($sformatf("sweep_d1_%0d", i), D1, 16'(i * 15));
            check_eq($sformatf("sweep_d2_%0d", i), D2, 16'(((i + 1) % 16) * 15));
        end

        // Streaming writes to entry 2, then a one-edge reset mid-stream.
        tick();
        W = 4'd2;
        stream = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            stream = stream + 16'h000F;
            Da = stream;
            tick();
            check_eq($sformatf("stream_n2_%0d", k), dut.N[2], stream);
        end
        stream = stream + 16'h000F;
        Da  = stream;
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        for (int a = 0; a < 16; a++) begin
            check_eq($sformatf("midrst_n%0d", a), dut.N[a], 16'h0000);
        end
        Re1 = 4'd2;
        Re2 = 4'd9;
        #1;
        check_eq("midrst_d1_a2", D1, 16'h0000);
        check_eq("midrst_d2_a9", D2, 16'h0000);
        stream = stream + 16'h000F;
        Da = stream;
        tick();
        check_eq("resume_d1_a2", D1, 16'h004B);
        check_eq("resume_n3", dut.N[3], 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_reg_file
